// File: rtl/riscv_test_monitor_pkg.sv
// Shared definitions for the riscv-tests pass/fail monitor: FSM states,
// default end PC and the gp result encoding used by riscv-tests.
package riscv_test_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_END_PC = 32'h0000_0044;

    // riscv-tests writes gp=1 on pass, otherwise (test_num << 1) | 1
    localparam int unsigned PASS_GP       = 1;
    localparam int unsigned GP_FAIL_SHIFT = 1;

endpackage

// File: rtl/riscv_test_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr and rst both
// return it to zero.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/riscv_test_monitor.sv
// Watches the core's pc/gp/retire outputs, latches the riscv-tests verdict
// when the end PC is reached, and declares a timeout after TICKS run cycles.
module riscv_test_monitor
    import riscv_test_monitor_pkg::*;
#(
    parameter int              XLEN   = 32,
    parameter logic [XLEN-1:0] END_PC = XLEN'(DEFAULT_END_PC),
    parameter int              TICKS  = 5000,
    parameter int              CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  gp_i,
    input  logic             retire_i,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [XLEN-2:0]  fail_test_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic            r_pass;
    logic            r_fail;
    logic            r_timeout;
    logic [XLEN-2:0] r_fail_test;
    logic            w_pass_next;
    logic            w_fail_next;
    logic            w_timeout_next;
    logic [XLEN-2:0] w_fail_test_next;

    logic             w_run;
    logic             w_clr;
    logic             w_hit;
    logic             w_last_tick;
    logic [CNT_W-1:0] w_cycles;
    logic [CNT_W-1:0] w_retired;

    assign w_run       = (r_state == ST_RUN);
    assign w_clr       = (r_state == ST_IDLE);
    assign w_hit       = (pc_i == END_PC);
    assign w_last_tick = (w_cycles == LAST_TICK);

    // Counters advance on the DONE-entry edge too, so the hit cycle is counted.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_run),
        .count (w_cycles)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_run && retire_i),
        .count (w_retired)
    );

    always_comb begin
        w_state_next     = r_state;
        w_pass_next      = r_pass;
        w_fail_next      = r_fail;
        w_timeout_next   = r_timeout;
        w_fail_test_next = r_fail_test;
        case (r_state)
            ST_IDLE: w_state_next = ST_RUN;
            ST_RUN: begin
                // End-PC verdict takes priority over a coincident timeout.
                if (w_hit) begin
                    w_state_next = ST_DONE;
                    if (gp_i == XLEN'(PASS_GP)) begin
                        w_pass_next = 1'b1;
                    end else begin
                        w_fail_next      = 1'b1;
                        w_fail_test_next = gp_i[XLEN-1:GP_FAIL_SHIFT];
                    end
                end else if (w_last_tick) begin
                    w_state_next   = ST_DONE;
                    w_timeout_next = 1'b1;
                end
            end
            ST_DONE: w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_test <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pass      <= w_pass_next;
            r_fail      <= w_fail_next;
            r_timeout   <= w_timeout_next;
            r_fail_test <= w_fail_test_next;
        end
    end

    assign done_o      = r_pass | r_fail | r_timeout;
    assign pass_o      = r_pass;
    assign fail_o      = r_fail;
    assign timeout_o   = r_timeout;
    assign fail_test_o = r_fail_test;
    assign cycles_o    = w_cycles;
    assign retired_o   = w_retired;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: two instances (TICKS=50 and TICKS=20) share
// stimulus; each is compared every cycle to a run-level model, plus table checks.
module tb_riscv_test_monitor;

    localparam logic [31:0] END = 32'h44;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic [31:0] gp_i = '0;
    logic        retire_i = 1'b0;

    logic        done_a, pass_a, fail_a, tmo_a;
    logic [30:0] ft_a;
    logic [31:0] cyc_a, ret_a;
    logic        done_b, pass_b, fail_b, tmo_b;
    logic [30:0] ft_b;
    logic [31:0] cyc_b, ret_b;

    always #5 clk = ~clk;

    riscv_test_monitor #(.XLEN(32), .END_PC(END), .TICKS(50), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .pc_i(pc_i), .gp_i(gp_i), .retire_i(retire_i),
        .done_o(done_a), .pass_o(pass_a), .fail_o(fail_a), .timeout_o(tmo_a),
        .fail_test_o(ft_a), .cycles_o(cyc_a), .retired_o(ret_a)
    );

    riscv_test_monitor #(.XLEN(32), .END_PC(END), .TICKS(20), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst), .pc_i(pc_i), .gp_i(gp_i), .retire_i(retire_i),
        .done_o(done_b), .pass_o(pass_b), .fail_o(fail_b), .timeout_o(tmo_b),
        .fail_test_o(ft_b), .cycles_o(cyc_b), .retired_o(ret_b)
    );

    // Run-level reference: a run is "started" one edge after reset release,
    // then counts cycles until it finishes by verdict or by reaching ticks.
    typedef struct {
        bit          started;
        bit          finished;
        bit          pass;
        bit          fail;
        bit          tmo;
        logic [30:0] ft;
        int unsigned cycles;
        int unsigned retired;
    } model_t;

    typedef struct {
        string       name;
        int          hit_at;
        logic [31:0] gp_end;
        int          mode;
        int          hold;
        bit          e_pass;
        bit          e_fail;
        bit          e_tmo;
        logic [30:0] e_ft;
        int          e_cyc;
        int          e_ret;
    } vec_t;

    model_t ma, mb;
    int     errors = 0;
    int     checks = 0;

    function automatic model_t model_step(model_t m, int unsigned ticks, logic [31:0] pc,
                                          logic [31:0] gp, logic ret, logic rv);
        model_t n = m;
        if (rv) begin
            n.started = 0; n.finished = 0; n.pass = 0; n.fail = 0; n.tmo = 0;
            n.ft = '0; n.cycles = 0; n.retired = 0;
        end else if (!m.started) begin
            n.started = 1;
        end else if (!m.finished) begin
            n.cycles = m.cycles + 1;
            if (ret) n.retired = m.retired + 1;
            if (pc == END) begin
                n.finished = 1;
                if (gp == 32'd1) n.pass = 1;
                else begin
                    n.fail = 1;
                    n.ft   = gp[31:1];
                end
            end else if (n.cycles == ticks) begin
                n.finished = 1;
                n.tmo      = 1;
            end
        end
        return n;
    endfunction

    function automatic logic [98:0] pack_model(model_t m);
        return {m.finished, m.pass, m.fail, m.tmo, m.ft, m.cycles, m.retired};
    endfunction

    task automatic check_vec(input string name, input logic [98:0] act, input logic [98:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [31:0] pc, input logic [31:0] gp, input logic ret,
                         input logic rv);
        rst = rv; pc_i = pc; gp_i = gp; retire_i = ret;
        @(posedge clk);
        ma = model_step(ma, 50, pc, gp, ret, rv);
        mb = model_step(mb, 20, pc, gp, ret, rv);
        #1;
        check_vec("cycle_a", {done_a, pass_a, fail_a, tmo_a, ft_a, cyc_a, ret_a}, pack_model(ma));
        check_vec("cycle_b", {done_b, pass_b, fail_b, tmo_b, ft_b, cyc_b, ret_b}, pack_model(mb));
    endtask

    function automatic logic [31:0] run_pc(int i);
        logic [31:0] p = 32'(4 * i);
        if (p == END) p = p + 32'h1000;
        return p;
    endfunction

    function automatic logic retire_of(int mode, int i);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (i % 2) == 1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic start_run();
        cycle(32'h0, 32'h0, 1'b0, 1'b1);
        cycle(32'h0, 32'h0, 1'b0, 1'b1);
        cycle(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic run_scenario(input int hit_at, input logic [31:0] gp_end, input int mode,
                                input int hold, input bit rand_rst);
        int r;
        start_run();
        for (int i = 0; i < hit_at; i++)
            cycle(run_pc(i), $urandom, retire_of(mode, i), 1'b0);
        cycle(END, gp_end, retire_of(mode, hit_at), 1'b0);
        for (int j = 0; j < hold; j++) begin
            r = $urandom_range(0, 3);
            cycle((r == 0) ? END : $urandom, (r == 0) ? 32'd1 : $urandom,
                  1'($urandom_range(0, 1)),
                  rand_rst && ($urandom_range(0, 15) == 0));
        end
    endtask

    vec_t tbl[9];

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};

        tbl[0] = '{"pass_run",   17, 32'h1,         0, 100, 1, 0, 0, 31'h0,         18, 18};
        tbl[1] = '{"fail_run",   10, 32'h7,         0, 5,   0, 1, 0, 31'h3,         11, 11};
        tbl[2] = '{"fail_gp0",   5,  32'h0,         0, 5,   0, 1, 0, 31'h0,         6,  6};
        tbl[3] = '{"fail_high",  3,  32'hFFFF_FFFE, 0, 5,   0, 1, 0, 31'h7FFF_FFFF, 4,  4};
        tbl[4] = '{"retire_gap", 20, 32'h1,         1, 5,   1, 0, 0, 31'h0,         21, 10};
        tbl[5] = '{"timeout",    80, 32'h1,         0, 10,  0, 0, 1, 31'h0,         50, 50};
        tbl[6] = '{"simul_b",    19, 32'h1,         0, 5,   1, 0, 0, 31'h0,         20, 20};
        tbl[7] = '{"hit_first",  0,  32'h1,         0, 3,   1, 0, 0, 31'h0,         1,  1};
        tbl[8] = '{"simul_a",    49, 32'h5,         0, 3,   0, 1, 0, 31'h2,         50, 50};

        for (int k = 0; k < 9; k++) begin
            run_scenario(tbl[k].hit_at, tbl[k].gp_end, tbl[k].mode, tbl[k].hold, 1'b0);
            check_vec(tbl[k].name, {done_a, pass_a, fail_a, tmo_a, ft_a, cyc_a, ret_a},
                      {tbl[k].e_pass | tbl[k].e_fail | tbl[k].e_tmo, tbl[k].e_pass,
                       tbl[k].e_fail, tbl[k].e_tmo, tbl[k].e_ft,
                       32'(tbl[k].e_cyc), 32'(tbl[k].e_ret)});
            if (k == 6)
                check_vec("simul_b_flags", {65'd0, pass_b, tmo_b, cyc_b},
                          {65'd0, 1'b1, 1'b0, 32'd20});
            $display("vector %s: done=%0b pass=%0b fail=%0b tmo=%0b ft=%0h cyc=%0d ret=%0d",
                     tbl[k].name, done_a, pass_a, fail_a, tmo_a, ft_a, cyc_a, ret_a);
        end

        // Reset mid-run, then a fresh pass run counted from the new release.
        start_run();
        for (int i = 0; i < 10; i++) cycle(run_pc(i), 32'h0, 1'b1, 1'b0);
        cycle(32'h0, 32'h0, 1'b1, 1'b1);
        check_vec("midrun_rst", {done_a, pass_a, fail_a, tmo_a, ft_a, cyc_a, ret_a}, 99'd0);
        cycle(32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(run_pc(i), 32'h0, 1'b1, 1'b0);
        cycle(END, 32'h1, 1'b1, 1'b0);
        check_vec("post_rst_pass", {66'd0, pass_a, cyc_a}, {66'd0, 1'b1, 32'd6});
        cycle(END, 32'h1, 1'b1, 1'b1);
        check_vec("done_rst", {done_b, pass_b, fail_b, tmo_b, ft_b, cyc_b, ret_b}, 99'd0);
        $display("sequence reset_mid_run: cyc=%0d", cyc_a);

        for (int n = 0; n < 25; n++) begin
            run_scenario($urandom_range(0, 70),
                         ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom,
                         2, $urandom_range(0, 12), 1'b1);
            $display("random run %0d: a(p%0b f%0b t%0b c%0d) b(p%0b f%0b t%0b c%0d)",
                     n, pass_a, fail_a, tmo_a, cyc_a, pass_b, fail_b, tmo_b, cyc_b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
